io_core_banked: RTL

- Parametrised successor to the fixed-probe IO core: N_IN input probe channels and N_OUT output probe channels of configurable width.
- All channels are memory-mapped onto the daisy-chained 16-bit manta bus.
- A strobe register snapshots inputs and commits outputs atomically.
- Adds a capture counter and a per-channel change mask; sits in the manta core chain between the UART interface and downstream cores.

---
 rtl/io_core_banked.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/io_core_banked.sv
// io_core_banked: parametrised memory-mapped probe core on the daisy-chained
// 16-bit manta bus. Input channels are snapshotted and output channels are
// committed together by a 0->1 write to the STROBE register.
module io_core_banked #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned N_IN      = 4,
  parameter int unsigned IN_WIDTH  = 20,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned OUT_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                addr_i,
  input  logic [15:0]                data_i,
  input  logic                       rw_i,
  input  logic                       valid_i,
  output logic [15:0]                addr_o,
  output logic [15:0]                data_o,
  output logic                       rw_o,
  output logic                       valid_o,
  input  logic [N_IN*IN_WIDTH-1:0]   probes_in,
  output logic [N_OUT*OUT_WIDTH-1:0] probes_out
);

  localparam int unsigned WI      = (IN_WIDTH + 15) / 16;
  localparam int unsigned WO      = (OUT_WIDTH + 15) / 16;
  localparam int unsigned IBW     = WI * 16;
  localparam int unsigned OBW     = WO * 16;
  localparam int unsigned IB_BASE = 3;
  localparam int unsigned OB_BASE = IB_BASE + N_IN * WI;
  localparam int unsigned SPAN    = OB_BASE + N_OUT * WO;

  // Bits of an OUT_BUF channel that actually exist; everything above reads 0.
  localparam logic [OBW-1:0] OUT_MASK = {OBW{1'b1}} >> (OBW - OUT_WIDTH);

  logic             r_strobe;
  logic [15:0]      r_count;
  logic [N_IN-1:0]  r_changed;
  logic [IBW-1:0]   r_in_buf  [N_IN];
  logic [OBW-1:0]   r_out_buf [N_OUT];

  logic [31:0]      w_addr32;
  logic [31:0]      w_off;
  logic             w_hit;
  logic             w_rd_hit;
  logic             w_wr_hit;
  logic             w_strobe_evt;
  logic [15:0]      w_rdata;
  logic [IBW-1:0]   w_snap [N_IN];

  // Address decode in 32 bits so BASE_ADDR+SPAN past 0xFFFF cannot wrap.
  always_comb begin
    w_addr32     = 32'(addr_i);
    w_off        = w_addr32 - 32'(BASE_ADDR);
    w_hit        = valid_i && (w_addr32 >= 32'(BASE_ADDR))
                           && (w_addr32 < 32'(BASE_ADDR + SPAN));
    w_rd_hit     = w_hit && !rw_i;
    w_wr_hit     = w_hit && rw_i;
    w_strobe_evt = w_wr_hit && (w_off == 32'd0) && data_i[0] && !r_strobe;
  end

  // Zero-extended view of the live probe inputs, one entry per channel.
  always_comb begin
    for (int k = 0; k < int'(N_IN); k++) begin
      w_snap[k] = IBW'(probes_in[k*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // Register read mux by offset; unmapped offsets never reach here (w_rd_hit).
  always_comb begin
    w_rdata = '0;
    if (w_off == 32'd0) begin
      w_rdata = 16'(r_strobe);
    end else if (w_off == 32'd1) begin
      w_rdata = r_count;
    end else if (w_off == 32'd2) begin
      w_rdata = 16'(r_changed);
    end
    for (int k = 0; k < int'(N_IN); k++) begin
      for (int j = 0; j < int'(WI); j++) begin
        if (w_off == 32'(IB_BASE + 32'(k) * WI + 32'(j))) begin
          w_rdata = r_in_buf[k][j*16 +: 16];
        end
      end
    end
    for (int k = 0; k < int'(N_OUT); k++) begin
      for (int j = 0; j < int'(WO); j++) begin
        if (w_off == 32'(OB_BASE + 32'(k) * WO + 32'(j))) begin
          w_rdata = r_out_buf[k][j*16 +: 16];
        end
      end
    end
  end

  // One-cycle bus pipeline; read hits substitute register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o  <= '0;
      data_o  <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      addr_o  <= addr_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
      data_o  <= w_rd_hit ? w_rdata : data_i;
    end
  end

  // STROBE and OUT_BUF write handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe <= 1'b0;
      for (int k = 0; k < int'(N_OUT); k++) begin
        r_out_buf[k] <= '0;
      end
    end else begin
      if (w_wr_hit && (w_off == 32'd0)) begin
        r_strobe <= data_i[0];
      end
      for (int k = 0; k < int'(N_OUT); k++) begin
        for (int j = 0; j < int'(WO); j++) begin
          if (w_wr_hit && (w_off == 32'(OB_BASE + 32'(k) * WO + 32'(j)))) begin
            r_out_buf[k][j*16 +: 16] <= data_i & OUT_MASK[j*16 +: 16];
          end
        end
      end
    end
  end

  // Capture on a strobe event: snapshot inputs, flag changes, count, commit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_changed  <= '0;
      probes_out <= '0;
      for (int k = 0; k < int'(N_IN); k++) begin
        r_in_buf[k] <= '0;
      end
    end else if (w_strobe_evt) begin
      r_count <= r_count + 16'd1;
      for (int k = 0; k < int'(N_IN); k++) begin
        r_changed[k] <= (w_snap[k] != r_in_buf[k]);
        r_in_buf[k]  <= w_snap[k];
      end
      for (int k = 0; k < int'(N_OUT); k++) begin
        probes_out[k*OUT_WIDTH +: OUT_WIDTH] <= r_out_buf[k][OUT_WIDTH-1:0];
      end
    end
  end

endmodule
